// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the MIPS core:
// exception code encodings, default code width and the canonical NOP.
package pipe_pkg;

  localparam int PIPE_EXC_W = 5;

  typedef enum logic [PIPE_EXC_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_slice.sv
// One register slice of the inter-stage pipeline: clears on flush, holds on
// stall, otherwise loads the slot presented at its input.
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int EXC_W   = PIPE_EXC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               d_vld,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc,
  input  logic               d_bd,
  input  logic               d_exc_vld,
  input  logic [EXC_W-1:0]   d_exc_code,
  output logic               q_vld,
  output logic [INSTR_W-1:0] q_instr,
  output logic [PC_W-1:0]    q_pc,
  output logic               q_bd,
  output logic               q_exc_vld,
  output logic [EXC_W-1:0]   q_exc_code
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld      <= 1'b0;
      q_instr    <= '0;
      q_pc       <= '0;
      q_bd       <= 1'b0;
      q_exc_vld  <= 1'b0;
      q_exc_code <= '0;
    end else if (flush) begin
      q_vld      <= 1'b0;
      q_instr    <= '0;
      q_pc       <= '0;
      q_bd       <= 1'b0;
      q_exc_vld  <= 1'b0;
      q_exc_code <= '0;
    end else if (!stall) begin
      q_vld      <= d_vld;
      q_instr    <= d_instr;
      q_pc       <= d_pc;
      q_bd       <= d_bd;
      q_exc_vld  <= d_exc_vld;
      q_exc_code <= d_exc_code;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: DEPTH chained slices with stall, flush and
// exception merging in front of slice 0. PIPE_PERF_CNT_EN adds stall/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DEPTH   = 1,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int EXC_W   = PIPE_EXC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               bd_i,
  input  logic               exc_vld_i,
  input  logic [EXC_W-1:0]   exc_code_i,
  input  logic               new_exc_vld_i,
  input  logic [EXC_W-1:0]   new_exc_code_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               bd_o,
  output logic               exc_vld_o,
  output logic [EXC_W-1:0]   exc_code_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  logic               m_vld;
  logic [INSTR_W-1:0] m_instr;
  logic [PC_W-1:0]    m_pc;
  logic               m_bd;
  logic               m_exc_vld;
  logic [EXC_W-1:0]   m_exc_code;

  logic               s_vld      [DEPTH];
  logic [INSTR_W-1:0] s_instr    [DEPTH];
  logic [PC_W-1:0]    s_pc       [DEPTH];
  logic               s_bd       [DEPTH];
  logic               s_exc_vld  [DEPTH];
  logic [EXC_W-1:0]   s_exc_code [DEPTH];

  // Merge stage: the older (upstream) exception wins; a faulting slot becomes a
  // NOP so no later stage commits state, but keeps pc/bd for EPC.
  always_comb begin
    m_vld      = valid_i;
    m_instr    = instr_i;
    m_pc       = pc_i;
    m_bd       = bd_i;
    m_exc_vld  = 1'b0;
    m_exc_code = EXC_W'(EXC_INT);
    if (!valid_i) begin
      m_instr = '0;
      m_pc    = '0;
      m_bd    = 1'b0;
    end else begin
      if (exc_vld_i) begin
        m_exc_vld  = 1'b1;
        m_exc_code = exc_code_i;
      end else if (new_exc_vld_i) begin
        m_exc_vld  = 1'b1;
        m_exc_code = new_exc_code_i;
      end
      if (m_exc_vld) m_instr = INSTR_W'(NOP_INSTR);
    end
  end

  // Slice chain: slice 0 takes the merged slot, slice k takes slice k-1.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    if (k == 0) begin : g_head
      pipe_slice #(.INSTR_W(INSTR_W), .PC_W(PC_W), .EXC_W(EXC_W)) u_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall_i),
        .flush      (flush_i),
        .d_vld      (m_vld),
        .d_instr    (m_instr),
        .d_pc       (m_pc),
        .d_bd       (m_bd),
        .d_exc_vld  (m_exc_vld),
        .d_exc_code (m_exc_code),
        .q_vld      (s_vld[k]),
        .q_instr    (s_instr[k]),
        .q_pc       (s_pc[k]),
        .q_bd       (s_bd[k]),
        .q_exc_vld  (s_exc_vld[k]),
        .q_exc_code (s_exc_code[k])
      );
    end else begin : g_body
      pipe_slice #(.INSTR_W(INSTR_W), .PC_W(PC_W), .EXC_W(EXC_W)) u_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall_i),
        .flush      (flush_i),
        .d_vld      (s_vld[k-1]),
        .d_instr    (s_instr[k-1]),
        .d_pc       (s_pc[k-1]),
        .d_bd       (s_bd[k-1]),
        .d_exc_vld  (s_exc_vld[k-1]),
        .d_exc_code (s_exc_code[k-1]),
        .q_vld      (s_vld[k]),
        .q_instr    (s_instr[k]),
        .q_pc       (s_pc[k]),
        .q_bd       (s_bd[k]),
        .q_exc_vld  (s_exc_vld[k]),
        .q_exc_code (s_exc_code[k])
      );
    end
  end

  assign valid_o    = s_vld[DEPTH-1];
  assign instr_o    = s_instr[DEPTH-1];
  assign pc_o       = s_pc[DEPTH-1];
  assign bd_o       = s_bd[DEPTH-1];
  assign exc_vld_o  = s_exc_vld[DEPTH-1];
  assign exc_code_o = s_exc_code[DEPTH-1];

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  // A cycle with both flush and stall counts only as a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else if (flush_i) begin
      flush_cnt_o <= sat_inc(flush_cnt_o);
    end else if (stall_i) begin
      stall_cnt_o <= sat_inc(stall_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg (DEPTH=2): directed cases plus randomized traffic
// against a queue-based slot model; checks counters when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_reg;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic        ev;
    logic [4:0]  ec;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, valid_i, bd_i, exc_vld_i, new_exc_vld_i;
  logic [31:0] instr_i, pc_i;
  logic [4:0]  exc_code_i, new_exc_code_i;
  logic        valid_o, bd_o, exc_vld_o;
  logic [31:0] instr_o, pc_o;
  logic [4:0]  exc_code_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
  longint      exp_stall_cnt, exp_flush_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  slot_t pipe[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32), .EXC_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .valid_i        (valid_i),
    .instr_i        (instr_i),
    .pc_i           (pc_i),
    .bd_i           (bd_i),
    .exc_vld_i      (exc_vld_i),
    .exc_code_i     (exc_code_i),
    .new_exc_vld_i  (new_exc_vld_i),
    .new_exc_code_i (new_exc_code_i),
    .valid_o        (valid_o),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .bd_o           (bd_o),
    .exc_vld_o      (exc_vld_o),
    .exc_code_o     (exc_code_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic slot_t bubble();
    slot_t s;
    s = '0;
    return s;
  endfunction

  // Slot that the upstream stage hands over this cycle, after exception merging.
  function automatic slot_t incoming();
    slot_t s;
    s = '0;
    if (valid_i) begin
      s.v  = 1'b1;
      s.pc = pc_i;
      s.bd = bd_i;
      s.ev = exc_vld_i | new_exc_vld_i;
      s.ec = exc_vld_i ? exc_code_i : (new_exc_vld_i ? new_exc_code_i : 5'd0);
      s.instr = s.ev ? 32'd0 : instr_i;
    end
    return s;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(bubble());
`ifdef PIPE_PERF_CNT_EN
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
`endif
  endtask

  task automatic compare_outputs();
    slot_t e;
    e = pipe[DEPTH-1];
    check_eq("valid_o",    64'(valid_o),    64'(e.v));
    check_eq("instr_o",    64'(instr_o),    64'(e.instr));
    check_eq("pc_o",       64'(pc_o),       64'(e.pc));
    check_eq("bd_o",       64'(bd_o),       64'(e.bd));
    check_eq("exc_vld_o",  64'(exc_vld_o),  64'(e.ev));
    check_eq("exc_code_o", 64'(exc_code_o), 64'(e.ec));
`ifdef PIPE_PERF_CNT_EN
    check_eq("stall_cnt_o", 64'(stall_cnt_o), 64'(exp_stall_cnt));
    check_eq("flush_cnt_o", 64'(flush_cnt_o), 64'(exp_flush_cnt));
`endif
  endtask

  // One clock edge: advance the model by the slot rules, then check.
  task automatic step();
    @(posedge clk);
    if (flush_i) begin
      foreach (pipe[i]) pipe[i] = bubble();
    end else if (!stall_i) begin
      pipe.push_front(incoming());
      void'(pipe.pop_back());
    end
`ifdef PIPE_PERF_CNT_EN
    if (flush_i) begin
      if (exp_flush_cnt < 64'hFFFF_FFFF) exp_flush_cnt++;
    end else if (stall_i) begin
      if (exp_stall_cnt < 64'hFFFF_FFFF) exp_stall_cnt++;
    end
`endif
    #1;
    compare_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic bd, input logic ev, input logic [4:0] ec,
                       input logic nev, input logic [4:0] nec);
    valid_i = v; instr_i = ins; pc_i = pc; bd_i = bd;
    exc_vld_i = ev; exc_code_i = ec; new_exc_vld_i = nev; new_exc_code_i = nec;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(valid_o), 64'd0);
    check_eq({tag, "_instr"}, 64'(instr_o), 64'd0);
    check_eq({tag, "_pc"},    64'(pc_o),    64'd0);
    check_eq({tag, "_bd"},    64'(bd_o),    64'd0);
    check_eq({tag, "_exc"},   64'({exc_vld_o, exc_code_o}), 64'd0);
  endtask

  function automatic logic [4:0] rand_code();
    logic [4:0] codes [5];
    codes = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
    return codes[$urandom_range(4, 0)];
  endfunction

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    compare_outputs();
    rst_n = 1'b1;

    // Latency: valid slot appears after exactly DEPTH edges, unchanged.
    drive(1'b1, 32'h2408_0005, 32'h3000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    check_eq("lat_not_early", 64'(valid_o), 64'd0);
    step();
    check_eq("lat_instr", 64'(instr_o), 64'h2408_0005);
    check_eq("lat_pc",    64'(pc_o),    64'h3000);
    check_eq("lat_valid", 64'(valid_o), 64'd1);

    // Stall of 3 cycles holds the last slice and loses nothing.
    drive(1'b1, 32'h1111_0001, 32'h3004, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    drive(1'b1, 32'h1111_0002, 32'h3008, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    check_eq("pre_stall_pc", 64'(pc_o), 64'h3004);
    stall_i = 1'b1;
    drive(1'b1, 32'h1111_0003, 32'h300C, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_hold_pc", 64'(pc_o), 64'h3004);
    end
    stall_i = 1'b0;
    step();
    check_eq("post_stall_pc", 64'(pc_o), 64'h3008);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    check_eq("post_stall_pc2", 64'(pc_o), 64'h300C);

    // Flush with stall together wins as flush.
    drive(1'b1, 32'h2222_0001, 32'h5000, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    step();
    stall_i = 1'b1;
    flush_i = 1'b1;
    step();
    check_eq("flush_valid", 64'(valid_o), 64'd0);
    check_eq("flush_instr", 64'(instr_o), 64'd0);
    stall_i = 1'b0;
    flush_i = 1'b0;

    // Exception merge: upstream code beats the new one, instr killed.
    drive(1'b1, 32'h8C01_0000, 32'h4000, 1'b1, 1'b1, 5'd4, 1'b1, 5'd12);
    step();
    drive(1'b1, 32'h0000_0020, 32'h4004, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0);
    step();
    check_eq("exc_code",  64'(exc_code_o), 64'd4);
    check_eq("exc_vld",   64'(exc_vld_o),  64'd1);
    check_eq("exc_instr", 64'(instr_o),    64'd0);
    check_eq("exc_pc",    64'(pc_o),       64'h4000);
    check_eq("exc_bd",    64'(bd_o),       64'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    check_eq("int_vld",   64'(exc_vld_o),  64'd1);
    check_eq("int_code",  64'(exc_code_o), 64'd0);

    // Asynchronous reset mid-stall, between clock edges.
    drive(1'b1, 32'h3333_0001, 32'h6000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    step();
    stall_i = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall_i = 1'b0;

`ifdef PIPE_PERF_CNT_EN
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    stall_i = 1'b1;
    repeat (5) step();
    stall_i = 1'b0;
    flush_i = 1'b1;
    repeat (2) step();
    stall_i = 1'b1;
    step();
    stall_i = 1'b0;
    flush_i = 1'b0;
    step();
    check_eq("perf_stall", 64'(stall_cnt_o), 64'd5);
    check_eq("perf_flush", 64'(flush_cnt_o), 64'd3);
`endif

    // Randomized traffic against the slot model.
    for (int i = 0; i < 400; i++) begin
      stall_i = ($urandom_range(3, 0) == 0);
      flush_i = ($urandom_range(9, 0) == 0);
      drive($urandom_range(3, 0) != 0, $urandom(), $urandom(), 1'($urandom_range(1, 0)),
            $urandom_range(5, 0) == 0, rand_code(),
            $urandom_range(4, 0) == 0, rand_code());
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks done", n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core with precise exceptions. It carries instruction, PC, delay-slot flag, valid bit and exception status between two adjacent stages (D/E, E/M, M/W) through a configurable number of register slices. It supports hold (stall), flush-to-bubble and in-stage exception merging, so one block replaces every per-stage instruction latch.

## Interface
- DEPTH, 1: number of chained register slices, 1..4; latency in cycles
- INSTR_W, 32: instruction width
- PC_W, 32: PC width
- EXC_W, 5: exception code width

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  hold all slices
- flush_i  in  1  clear all slices to bubble
- valid_i  in  1  upstream slot holds a real instruction
- instr_i  in  INSTR_W  upstream instruction
- pc_i  in  PC_W  upstream PC
- bd_i  in  1  upstream instruction sits in a branch delay slot
- exc_vld_i  in  1  exception already raised upstream
- exc_code_i  in  EXC_W  upstream exception code
- new_exc_vld_i  in  1  exception detected in the current stage
- new_exc_code_i  in  EXC_W  code of that exception
- valid_o  out  1  last slice valid
- instr_o  out  INSTR_W  last slice instruction
- pc_o  out  PC_W  last slice PC
- bd_o  out  1  last slice delay-slot flag
- exc_vld_o  out  1  last slice carries an exception
- exc_code_o  out  EXC_W  last slice exception code

## Operation
- Reset (rst_n low, any time, mid-stall included): every slice cleared; all outputs 0.
- Priority per edge: flush_i > stall_i > normal advance.
- flush_i: every slice becomes a bubble (valid 0, instr 0, pc 0, bd 0, exc 0), regardless of stall_i.
- stall_i without flush: every slice holds its value; inputs ignored.
- Advance: slice k+1 takes slice k; slice 0 takes the merged input.
- Merge at slice 0, only if valid_i=1:
  - exc_vld_i=1: keep exc_code_i (older exception wins).
  - else new_exc_vld_i=1: take new_exc_code_i.
  - else exc_vld=0, code 0.
  - Merged exc_vld=1 forces the stored instr to 0 (nop) so no later stage writes state; pc and bd are kept for EPC.
- valid_i=0: slice 0 loads a bubble; exception inputs ignored.
- Code 0 with exc_vld=1 (interrupt) is a legal exception; exc_vld alone marks presence.

## Timing
- Latency: DEPTH cycles from input edge to output, absent stall/flush.
- Stall of N cycles adds exactly N cycles; no data lost or duplicated.
- Flush takes effect at the same edge; outputs show bubble in the following cycle.
- Simultaneous flush_i and stall_i: flush.
- Outputs are purely registered; no combinational input-to-output path.

## Configuration
- PIPE_PERF_CNT_EN defined: adds outputs stall_cnt_o and flush_cnt_o, both 32 bits, reset 0, saturating at 0xFFFFFFFF. stall_cnt_o increments on cycles with stall_i=1, flush_i=0. flush_cnt_o increments on cycles with flush_i=1.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg:
  - EXC_W default
  - exception codes: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12
  - NOP instruction constant (0)
- Sub-module pipe_slice: one register slice with stall/flush/load. Instantiated DEPTH times with generate; the merge logic sits in front of slice 0.

## Test plan
- Reset: rst_n low mid-stream with valid slices → all outputs 0 immediately, without a clock edge.
- DEPTH=2: instr 0x24080005, pc 0x3000, valid → appears on outputs after exactly 2 edges, unchanged.
- Stall 3 cycles with pc 0x3004 in the last slice → outputs hold 0x3004 for 3 cycles, then advance with no lost slot.
- flush_i and stall_i together with valid data → valid_o=0, instr_o=0 next cycle.
- exc_vld_i=1 code 4 and new_exc_vld_i=1 code 12 → exc_code_o=4, instr_o=0, pc_o kept, bd_o kept.
- PIPE_PERF_CNT_EN: 5 stall cycles, 2 flush cycles, 1 cycle with both → stall_cnt_o=5, flush_cnt_o=3.
